// File: rtl/gated_sr_latch_core.sv
// Bank of independent gated SR latches with true/complement outputs and a
// per-bit flag for the forbidden S=R=1 input, modelled on the NAND gated SR latch.
`timescale 1ns/1ps
module gated_sr_latch_core #(
    parameter int WIDTH   = 1,
    parameter bit RESET_Q = 1'b0
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] P,
    output logic [WIDTH-1:0] INVALID
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_bit
            logic r_q;
            logic r_p;
            logic r_inv;
            logic w_forbid_now;

            // Storage only updates on an active request; S=R=0 leaves it untouched.
            always_latch begin
                if (!RESET_N) begin
                    r_q   <= RESET_Q;
                    r_p   <= ~RESET_Q;
                    r_inv <= 1'b0;
                end else if (CLK && (S[gi] || R[gi])) begin
                    r_q   <= S[gi];
                    r_p   <= R[gi];
                    r_inv <= S[gi] & R[gi];
                end
            end

            // A stored 1/1 is only visible while the gate is still open with S=R=1;
            // otherwise it resolves to Q=0, P=1.
            assign w_forbid_now = CLK & S[gi] & R[gi];
            assign Q[gi]        = r_q & ~(r_p & ~w_forbid_now);
            assign P[gi]        = r_p;
            assign INVALID[gi]  = r_inv;
        end
    endgenerate

endmodule

// File: tb/tb_gated_sr_latch_core.sv
// Directed bench for gated_sr_latch_core (WIDTH=4): single-bit scenarios are
// driven on all bits at once, followed by mixed per-bit patterns.
`timescale 1ns/1ps
module tb_gated_sr_latch_core;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] s;
    logic [W-1:0] r;
    logic [W-1:0] q;
    logic [W-1:0] p;
    logic [W-1:0] inv;

    int total = 0;
    int bad   = 0;

    gated_sr_latch_core #(
        .WIDTH  (W),
        .RESET_Q(1'b0)
    ) dut (
        .CLK    (clk),
        .RESET_N(rst_n),
        .S      (s),
        .R      (r),
        .Q      (q),
        .P      (p),
        .INVALID(inv)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [W-1:0] eq,
                        input logic [W-1:0] ep, input logic [W-1:0] ei);
        chk({tag, ".Q"}, q, eq);
        chk({tag, ".P"}, p, ep);
        chk({tag, ".INV"}, inv, ei);
        $display("step %s: S=%b R=%b CLK=%b RESET_N=%b -> Q=%b P=%b INVALID=%b",
                 tag, s, r, clk, rst_n, q, p, inv);
    endtask

    initial begin
        // Reset and release with gate closed
        rst_n = 1'b0; clk = 1'b0; s = '0; r = '0;
        #10 chk3("reset", 4'h0, 4'hF, 4'h0);
        rst_n = 1'b1;
        #10 chk3("release", 4'h0, 4'hF, 4'h0);

        // Gate closed: inputs ignored
        s = 4'hF; r = 4'h0;
        #100 chk3("closed_set", 4'h0, 4'hF, 4'h0);
        s = 4'h0; r = 4'hF;
        #100 chk3("closed_rst", 4'h0, 4'hF, 4'h0);
        s = 4'hF; r = 4'hF;
        #100 chk3("closed_11", 4'h0, 4'hF, 4'h0);

        // Transparent set / reset / hold
        s = 4'hF; r = 4'h0;
        #5 clk = 1'b1;
        #5 chk3("open_set", 4'hF, 4'h0, 4'h0);
        s = 4'h0; r = 4'hF;
        #5 chk3("open_rst", 4'h0, 4'hF, 4'h0);
        s = 4'h0; r = 4'h0;
        #5 chk3("open_hold", 4'h0, 4'hF, 4'h0);

        // Forbidden input and its resolution on gate close
        s = 4'hF; r = 4'hF;
        #5 chk3("forbid", 4'hF, 4'hF, 4'hF);
        clk = 1'b0;
        #5 chk3("forbid_close", 4'h0, 4'hF, 4'hF);
        s = 4'hF; r = 4'h0;
        #5 chk3("forbid_closed_set", 4'h0, 4'hF, 4'hF);
        clk = 1'b1;
        #5 chk3("forbid_exit", 4'hF, 4'h0, 4'h0);

        // Hold across gate close
        clk = 1'b0;
        #5 s = 4'h0; r = 4'hF;
        #5 chk3("hold_closed", 4'hF, 4'h0, 4'h0);
        clk = 1'b1;
        #5 chk3("hold_reopen", 4'h0, 4'hF, 4'h0);

        // Asynchronous reset while transparent
        s = 4'hF; r = 4'h0;
        #5 chk3("pre_reset", 4'hF, 4'h0, 4'h0);
        rst_n = 1'b0;
        #5 chk3("mid_reset", 4'h0, 4'hF, 4'h0);
        rst_n = 1'b1;
        #5 chk3("post_reset", 4'hF, 4'h0, 4'h0);

        // Independent bits
        s = 4'b0101; r = 4'b1010;
        #5 chk3("bits_pattern", 4'b0101, 4'b1010, 4'b0000);
        s = 4'b1100; r = 4'b0110;
        #5 chk3("bits_mixed", 4'b1101, 4'b0110, 4'b0100);
        clk = 1'b0;
        #5 chk3("bits_close", 4'b1001, 4'b0110, 4'b0100);
        #5 s = 4'b0100; r = 4'b0000;
        #5 clk = 1'b1;
        #5 chk3("bits_recover", 4'b1101, 4'b0010, 4'b0000);
        clk = 1'b0;
        #5 s = 4'b0000; r = 4'b0000;
        #5 chk3("bits_final", 4'b1101, 4'b0010, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gated_sr_latch_core.md
Name: gated_sr_latch_core

Overview:
- Bank of level-sensitive gated SR latches, behaviourally equivalent to the classic cross-coupled NAND gated SR latch.
- Provides true (Q) and complement (P) outputs, plus an INVALID flag for the forbidden S=R=1 condition.
- Used as a storage and flag-holding primitive in control paths where transparent-while-enabled capture is wanted.
- All bits share one gate (CLK) and one reset.

Parameters:
- WIDTH, 1, number of independent latch bits.
- RESET_Q, 0, value loaded into every Q bit on reset (1-bit, replicated); P takes the complement.

Ports:
- CLK  input  1  latch gate/enable, active-high level, not an edge clock
- RESET_N  input  1  asynchronous active-low reset
- S  input  WIDTH  per-bit set request
- R  input  WIDTH  per-bit reset request
- Q  output  WIDTH  latch true output
- P  output  WIDTH  latch complement output
- INVALID  output  WIDTH  per-bit forbidden-input indicator

Behaviour:
- Interface (already decided): one clock, CLK; reset is asynchronous and active-low, RESET_N.
- Reset, RESET_N=0:
  - Overrides everything immediately, independent of CLK, S and R.
  - Q = all RESET_Q, P = ~Q, INVALID = 0.
  - Release takes effect with no delay. If CLK=1 at release, the latch becomes transparent at once.
- Gate closed (CLK=0):
  - Q, P and INVALID hold their values.
  - S and R are ignored; any toggling has no effect.
- Gate open (CLK=1), per bit, combinational (zero-cycle transparency):
  - S=0, R=0: hold.
  - S=1, R=0: Q=1, P=0, INVALID=0.
  - S=0, R=1: Q=0, P=1, INVALID=0.
  - S=1, R=1: Q=1, P=1 (NAND forbidden state), INVALID=1.
- Forbidden-state exit, deterministic (no race modelled):
  - If the gate closes (CLK 1->0) while S=R=1, the bit resolves to Q=0, P=1. INVALID stays 1 while CLK=0.
  - If S or R drops while CLK=1, the bit follows the remaining request and INVALID clears.
  - INVALID also clears on reset or on the next valid (non 11) capture.
- Outside the forbidden state, P is always ~Q.
- Bits are fully independent; no cross-bit interaction.
- Simultaneous events:
  - Reset dominates gate and inputs.
  - A CLK falling edge coincident with an S/R change captures the pre-change value (inputs must meet hold around the gate falling edge; the bench changes them at least 1 ns apart).
- Implementation:
  - Level-sensitive storage (latch inference, or explicit NAND-pair modelling) with async reset.
  - No flip-flops.
  - Outputs are driven directly from the storage.

Test Plan:
- Reset check: RESET_N=0, CLK=0, S=0, R=0 -> Q=0, P=1, INVALID=0; release RESET_N, outputs unchanged.
- Gate closed: CLK=0; step S=1,R=0, then S=0,R=1, then S=1,R=1, each held 100 ns -> Q=0, P=1, INVALID=0 throughout.
- Transparent set/reset: CLK=1 with S=1,R=0 -> Q=1, P=0 immediately. Then S=0,R=1 -> Q=0, P=1. Then S=0,R=0 -> holds Q=0.
- Forbidden input: CLK=1, S=1, R=1 -> Q=1, P=1, INVALID=1. Drop CLK -> Q=0, P=1, INVALID=1. Raise CLK with S=1,R=0 -> Q=1, P=0, INVALID=0.
- Hold across gate close: CLK=1, S=1 -> Q=1. Drop CLK, then set S=0,R=1 -> Q stays 1. Raise CLK -> Q=0.
- Async reset mid-operation: CLK=1, S=1, Q=1; pulse RESET_N low between CLK edges -> Q=0, P=1 at once. Release with S still 1 and CLK=1 -> Q returns to 1. With WIDTH=4, S=4'b0101, R=4'b1010, CLK=1 -> Q=4'b0101, P=4'b1010.
